// File: rtl/shr_var.sv
// shr_var: joins a data token and a shift-amount token, shifts the data right
// by STEP bits per clock (logical or arithmetic), emits a one-cycle result pulse.
module shr_var #(
  parameter int N     = 16,
  parameter int STEP  = 1,
  parameter int ARITH = 0
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         EN,
  input  logic         R_IN_A,
  input  logic [N-1:0] D_IN_A,
  output logic         RDY_A,
  input  logic         R_IN_B,
  input  logic [N-1:0] D_IN_B,
  output logic         RDY_B,
  output logic         R_OUT,
  output logic [N-1:0] D_OUT
);

  localparam int CW = $clog2(N + 1);
  localparam logic [N-1:0]  L_N_DATA = N[N-1:0];
  localparam logic [CW-1:0] L_N_CNT  = N[CW-1:0];
  localparam logic [CW-1:0] L_STEP   = STEP[CW-1:0];

  typedef enum logic {
    COLLECT = 1'b0,
    SHIFT   = 1'b1
  } state_t;

  state_t        r_state;
  logic          r_full_a;
  logic          r_full_b;
  logic [N-1:0]  r_buf_a;
  logic [N-1:0]  r_buf_b;
  logic [N-1:0]  r_acc;
  logic [CW-1:0] r_cnt;
  logic          r_out;
  logic [N-1:0]  r_dout;

  logic          w_acc_a;
  logic          w_acc_b;
  logic [CW-1:0] w_amt;
  logic [CW-1:0] w_k;
  logic [N-1:0]  w_shr;

  assign RDY_A = EN && (r_state == COLLECT) && !r_full_a;
  assign RDY_B = EN && (r_state == COLLECT) && !r_full_b;
  assign R_OUT = r_out;
  assign D_OUT = r_dout;

  assign w_acc_a = RDY_A && R_IN_A;
  assign w_acc_b = RDY_B && R_IN_B;

  // Saturated shift amount, per-cycle step and the shifted accumulator
  always_comb begin
    w_amt = (r_buf_b > L_N_DATA) ? L_N_CNT : r_buf_b[CW-1:0];
    w_k   = (r_cnt < L_STEP) ? r_cnt : L_STEP;
    if (ARITH != 0) begin
      w_shr = $unsigned($signed(r_acc) >>> w_k);
    end else begin
      w_shr = r_acc >> w_k;
    end
  end

  // Token collection, shift sequencing and registered result pulse
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= COLLECT;
      r_full_a <= 1'b0;
      r_full_b <= 1'b0;
      r_buf_a  <= '0;
      r_buf_b  <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_out    <= 1'b0;
      r_dout   <= '0;
    end else if (EN) begin
      r_out <= 1'b0;
      case (r_state)
        COLLECT: begin
          if (r_full_a && r_full_b) begin
            r_state <= SHIFT;
            r_acc   <= r_buf_a;
            r_cnt   <= w_amt;
          end else begin
            if (w_acc_a) begin
              r_full_a <= 1'b1;
              r_buf_a  <= D_IN_A;
            end
            if (w_acc_b) begin
              r_full_b <= 1'b1;
              r_buf_b  <= D_IN_B;
            end
          end
        end
        SHIFT: begin
          if (r_cnt != '0) begin
            r_acc <= w_shr;
            r_cnt <= r_cnt - w_k;
          end else begin
            r_dout   <= r_acc;
            r_out    <= 1'b1;
            r_full_a <= 1'b0;
            r_full_b <= 1'b0;
            r_state  <= COLLECT;
          end
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_shr_var.sv
// Directed bench for shr_var: three instances share stimulus, each task
// checks the instance whose configuration the scenario needs.
//   u0: STEP=1 ARITH=0, u1: STEP=1 ARITH=1, u2: STEP=4 ARITH=0
module tb_shr_var;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        EN  = 1'b1;
  logic        ra  = 1'b0;
  logic        rb  = 1'b0;
  logic [15:0] da  = '0;
  logic [15:0] db  = '0;

  logic        rdy_a [3];
  logic        rdy_b [3];
  logic        rout  [3];
  logic [15:0] dout  [3];

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  shr_var #(.N(16), .STEP(1), .ARITH(0)) u0 (
    .CLK(CLK), .RST(RST), .EN(EN),
    .R_IN_A(ra), .D_IN_A(da), .RDY_A(rdy_a[0]),
    .R_IN_B(rb), .D_IN_B(db), .RDY_B(rdy_b[0]),
    .R_OUT(rout[0]), .D_OUT(dout[0]));

  shr_var #(.N(16), .STEP(1), .ARITH(1)) u1 (
    .CLK(CLK), .RST(RST), .EN(EN),
    .R_IN_A(ra), .D_IN_A(da), .RDY_A(rdy_a[1]),
    .R_IN_B(rb), .D_IN_B(db), .RDY_B(rdy_b[1]),
    .R_OUT(rout[1]), .D_OUT(dout[1]));

  shr_var #(.N(16), .STEP(4), .ARITH(0)) u2 (
    .CLK(CLK), .RST(RST), .EN(EN),
    .R_IN_A(ra), .D_IN_A(da), .RDY_A(rdy_a[2]),
    .R_IN_B(rb), .D_IN_B(db), .RDY_B(rdy_b[2]),
    .R_OUT(rout[2]), .D_OUT(dout[2]));

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; EN = 1'b1; ra = 1'b0; rb = 1'b0; da = '0; db = '0;
    tick();
    RST = 1'b0;
  endtask

  // both tokens presented for exactly one edge (edge e)
  task automatic send_pair(input logic [15:0] a, input logic [15:0] b);
    ra = 1'b1; da = a; rb = 1'b1; db = b;
    tick();
    ra = 1'b0; rb = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int d = 0; d < 3; d++) begin
      total++;
      if (rout[d] !== 1'b0 || dout[d] !== 16'h0000) begin
        bad++; $display("FAIL reset_out dut=%0d got r=%b d=%h exp r=0 d=0000", d, rout[d], dout[d]);
      end
      total++;
      if (rdy_a[d] !== 1'b1 || rdy_b[d] !== 1'b1) begin
        bad++; $display("FAIL reset_rdy dut=%0d got %b%b exp 11", d, rdy_a[d], rdy_b[d]);
      end
    end
    EN = 1'b0; #1;
    total++;
    if (rdy_a[0] !== 1'b0 || rdy_b[0] !== 1'b0) begin
      bad++; $display("FAIL reset_rdy_en0 got %b%b exp 00", rdy_a[0], rdy_b[0]);
    end
    EN = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    send_pair(16'hF0F0, 16'd4);
    for (int i = 1; i <= 7; i++) begin
      tick();
      total++;
      if (rout[0] !== (i == 6)) begin
        bad++; $display("FAIL basic_rout e+%0d got %b exp %b", i, rout[0], (i == 6));
      end
      if (i <= 5) begin
        total++;
        if (rdy_a[0] !== 1'b0 || rdy_b[0] !== 1'b0) begin
          bad++; $display("FAIL basic_rdy_busy e+%0d got %b%b exp 00", i, rdy_a[0], rdy_b[0]);
        end
      end
      if (i == 6) begin
        total++;
        if (dout[0] !== 16'h0F0F) begin
          bad++; $display("FAIL basic_dout got %h exp 0f0f", dout[0]);
        end
        total++;
        if (rdy_a[0] !== 1'b1 || rdy_b[0] !== 1'b1) begin
          bad++; $display("FAIL basic_rdy_back got %b%b exp 11", rdy_a[0], rdy_b[0]);
        end
      end
    end
  endtask

  task automatic test_skew();
    do_reset();
    ra = 1'b1; da = 16'h8000;
    tick();                       // edge 0: A accepted
    ra = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      total++;
      if (rdy_a[1] !== 1'b0 || rdy_b[1] !== 1'b1) begin
        bad++; $display("FAIL skew_rdy edge %0d got %b%b exp 01", i, rdy_a[1], rdy_b[1]);
      end
    end
    rb = 1'b1; db = 16'd3;
    tick();                       // edge 5: B accepted
    rb = 1'b0;
    for (int i = 6; i <= 11; i++) begin
      tick();
      total++;
      if (rout[1] !== (i == 10)) begin
        bad++; $display("FAIL skew_rout edge %0d got %b exp %b", i, rout[1], (i == 10));
      end
      if (i == 10) begin
        total++;
        if (dout[1] !== 16'hF000) begin
          bad++; $display("FAIL skew_dout got %h exp f000", dout[1]);
        end
      end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    send_pair(16'h8000, 16'd20);
    for (int i = 1; i <= 19; i++) begin
      tick();
      total++;
      if (rout[0] !== (i == 18) || rout[1] !== (i == 18)) begin
        bad++; $display("FAIL sat_rout e+%0d got %b%b exp %b", i, rout[0], rout[1], (i == 18));
      end
      if (i == 18) begin
        total++;
        if (dout[0] !== 16'h0000) begin
          bad++; $display("FAIL sat_logical got %h exp 0000", dout[0]);
        end
        total++;
        if (dout[1] !== 16'hFFFF) begin
          bad++; $display("FAIL sat_arith got %h exp ffff", dout[1]);
        end
      end
    end
  endtask

  task automatic test_step4();
    do_reset();
    send_pair(16'h1234, 16'd6);
    for (int i = 1; i <= 4; i++) begin
      tick();
      total++;
      if (rout[2] !== (i == 4)) begin
        bad++; $display("FAIL step4_rout1 e+%0d got %b exp %b", i, rout[2], (i == 4));
      end
    end
    total++;
    if (dout[2] !== 16'h0048) begin
      bad++; $display("FAIL step4_dout1 got %h exp 0048", dout[2]);
    end
    send_pair(16'hABCD, 16'd0);   // accepted on the edge after the first pulse
    total++;
    if (rout[2] !== 1'b0) begin
      bad++; $display("FAIL step4_gap got %b exp 0", rout[2]);
    end
    for (int j = 1; j <= 2; j++) begin
      tick();
      total++;
      if (rout[2] !== (j == 2)) begin
        bad++; $display("FAIL step4_rout2 e+%0d got %b exp %b", j, rout[2], (j == 2));
      end
    end
    total++;
    if (dout[2] !== 16'hABCD) begin
      bad++; $display("FAIL step4_dout2 got %h exp abcd", dout[2]);
    end
  endtask

  task automatic test_freeze();
    do_reset();
    send_pair(16'hF0F0, 16'd4);
    tick(); tick();               // e+1 enter SHIFT, e+2 first shift
    EN = 1'b0;
    for (int f = 0; f < 3; f++) begin
      tick();
      total++;
      if (rout[0] !== 1'b0 || rdy_a[0] !== 1'b0 || rdy_b[0] !== 1'b0) begin
        bad++; $display("FAIL freeze_shift got r=%b rdy=%b%b exp r=0 rdy=00", rout[0], rdy_a[0], rdy_b[0]);
      end
    end
    EN = 1'b1;
    for (int i = 3; i <= 6; i++) begin
      tick();
      total++;
      if (rout[0] !== (i == 6)) begin
        bad++; $display("FAIL freeze_rout en-edge %0d got %b exp %b", i, rout[0], (i == 6));
      end
    end
    total++;
    if (dout[0] !== 16'h0F0F) begin
      bad++; $display("FAIL freeze_dout got %h exp 0f0f", dout[0]);
    end
    EN = 1'b0;
    for (int f = 0; f < 3; f++) begin
      tick();
      total++;
      if (rout[0] !== 1'b1 || dout[0] !== 16'h0F0F || rdy_a[0] !== 1'b0) begin
        bad++; $display("FAIL freeze_pulse got r=%b d=%h rdya=%b exp r=1 d=0f0f rdya=0", rout[0], dout[0], rdy_a[0]);
      end
    end
    EN = 1'b1;
    tick();
    total++;
    if (rout[0] !== 1'b0 || rdy_a[0] !== 1'b1 || rdy_b[0] !== 1'b1) begin
      bad++; $display("FAIL freeze_release got r=%b rdy=%b%b exp r=0 rdy=11", rout[0], rdy_a[0], rdy_b[0]);
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    send_pair(16'hF0F0, 16'd4);
    tick(); tick();               // in SHIFT
    RST = 1'b1;
    tick();
    RST = 1'b0;
    total++;
    if (rout[0] !== 1'b0 || dout[0] !== 16'h0000 || rdy_a[0] !== 1'b1 || rdy_b[0] !== 1'b1) begin
      bad++; $display("FAIL rst_shift got r=%b d=%h rdy=%b%b exp r=0 d=0000 rdy=11", rout[0], dout[0], rdy_a[0], rdy_b[0]);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if (rout[0] !== 1'b0) begin
        bad++; $display("FAIL rst_stale cycle %0d got %b exp 0", i, rout[0]);
      end
    end
    // only A buffered, then reset: A must be forgotten
    ra = 1'b1; da = 16'h1234;
    tick();
    ra = 1'b0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    total++;
    if (rdy_a[0] !== 1'b1 || rdy_b[0] !== 1'b1) begin
      bad++; $display("FAIL rst_abuf_rdy got %b%b exp 11", rdy_a[0], rdy_b[0]);
    end
    rb = 1'b1; db = 16'd2;
    tick();
    rb = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (rout[0] !== 1'b0 || rdy_a[0] !== 1'b1) begin
        bad++; $display("FAIL rst_abuf_stale cycle %0d got r=%b rdya=%b exp r=0 rdya=1", i, rout[0], rdy_a[0]);
      end
    end
    ra = 1'b1; da = 16'h0F00;
    tick();                       // edge e: A joins buffered B=2
    ra = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      total++;
      if (rout[0] !== (i == 4)) begin
        bad++; $display("FAIL rst_next_rout e+%0d got %b exp %b", i, rout[0], (i == 4));
      end
    end
    total++;
    if (dout[0] !== 16'h03C0) begin
      bad++; $display("FAIL rst_next_dout got %h exp 03c0", dout[0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_skew();
    test_saturate();
    test_step4();
    test_freeze();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shr_var.md
# shr_var

Variable right shifter for the dataflow operator library. It joins a data token and a shift-amount token, each arriving on its own request channel. It then shifts the data right by STEP bit positions per clock, either logical or arithmetic, and emits the result as a one-cycle request pulse. It is the right-shift counterpart to the fixed left-shift operator. Operands can arrive skewed in time, and the output format matches the other operator blocks, so the block drops directly into generated dataflow graphs.

## Interface
- N, 16, data width of operands and result
- STEP, 1, bit positions shifted per SHIFT cycle; legal range 1..N
- ARITH, 0, 0 = logical (zero fill), 1 = arithmetic (fill with D_IN_A[N-1])
- CLK input 1: clock, all state on rising edge
- RST input 1: reset, synchronous, active-high
- EN input 1: global enable; when 0, all state and outputs are frozen
- R_IN_A input 1: data token request
- D_IN_A input N: data operand
- RDY_A output 1: block can accept a data token this cycle
- R_IN_B input 1: shift-amount token request
- D_IN_B input N: shift amount, unsigned
- RDY_B output 1: block can accept a shift-amount token this cycle
- R_OUT output 1: result request, one EN-cycle pulse
- D_OUT output N: result; holds the last result until the next one

## Operation
- Token accepted on channel x at a rising edge where EN=1 && R_IN_x=1 && RDY_x=1. Producers hold R_IN_x and D_IN_x until the token is accepted.
- Operand buffers: BUF_A and BUF_B, each one entry with a full flag.
- RDY_A = EN && state==COLLECT && !A_FULL; RDY_B follows the same rule with B_FULL. Both are combinational.
- State machine with two states, COLLECT and SHIFT:
  - COLLECT: accept tokens into empty buffers. A and B may both be accepted on the same edge.
  - COLLECT, both buffers full at the start of a cycle: move to SHIFT. On that edge, load acc=BUF_A and cnt=min(BUF_B, N).
  - SHIFT with cnt!=0: acc <= acc >> k and cnt <= cnt-k, where k=min(STEP, cnt). Fill bits are zero, or copies of acc[N-1] when ARITH=1.
  - SHIFT with cnt==0: D_OUT <= acc, R_OUT <= 1, both full flags cleared, state returns to COLLECT.
- Shift amounts ≥ N saturate to N:
  - result 0 when logical;
  - result all sign bits when arithmetic.
- Shift amount 0 passes the data unchanged.
- On any EN=1 edge that does not produce a result, R_OUT <= 0.
- cnt width is clog2(N+1). acc width is N.

## Timing
- Reset values:
  - R_OUT=0, D_OUT=0;
  - both full flags 0, state=COLLECT;
  - acc=0, cnt=0;
  - RDY_A and RDY_B are therefore 1 whenever EN=1 after reset.
- Latency: let edge e be the edge where the second operand is accepted. With c = min(amount, N), R_OUT is high after edge e + 2 + ceil(c/STEP), for that one EN-cycle only. Every count here is in EN=1 edges.
- Throughput: at most one result per 2 + ceil(c/STEP) cycles. RDY_A and RDY_B are 0 throughout SHIFT. They return to 1 in the cycle where R_OUT is high.
- If the first operand is already buffered, the next token of the same type is stalled (RDY=0) until the pair completes.
- EN=0 at any point:
  - every register holds, including R_OUT, so a pending pulse stays high until the next EN=1 edge;
  - RDY_A and RDY_B are 0, so nothing is accepted.
- RST mid-operation: the in-flight pair and any partially buffered operand are discarded, and all registers take their reset values on that edge. RST takes priority over EN.

## Test plan
- N=16, STEP=1, ARITH=0. A=0xF0F0 and B=4 accepted on the same edge e. Required: R_OUT=1 after edge e+6 only, D_OUT=0x0F0F, RDY_A=RDY_B=0 after edges e+1..e+5.
- ARITH=1, STEP=1. A=0x8000 accepted at edge 0, B=3 accepted at edge 5 (skewed arrival). Required: RDY_A=0 during edges 1..4, then R_OUT after edge 10 with D_OUT=0xF000.
- Saturation, STEP=1. B=20 with A=0x8000. Required: R_OUT after edge e+18 with D_OUT=0x0000 when ARITH=0, and D_OUT=0xFFFF when ARITH=1.
- STEP=4, ARITH=0. A=0x1234, B=6, then A=0xABCD, B=0. Required:
  - first result 0x0048 after edge e+4;
  - second result 0xABCD exactly 2 edges after its acceptance;
  - R_OUT low between the two results.
- EN=0 held for 3 cycles in the middle of SHIFT, and again while R_OUT=1. Required:
  - result and latency shifted by exactly the number of frozen cycles;
  - R_OUT stays high through the freeze and drops on the first EN=1 edge.
- RST asserted during SHIFT, and separately with only A buffered. Required:
  - all outputs reset (R_OUT=0, D_OUT=0, RDY_A=RDY_B=1 when EN=1);
  - no stale result is produced;
  - the next pair computes correctly.
